// File: rtl/trace_tx_sequencer_pkg.sv
// trace_tx_sequencer_pkg: segment codes and FSM encoding shared by the trace transmit sequencer.
package trace_tx_sequencer_pkg;

    localparam logic [1:0] SEG_PT  = 2'd0;
    localparam logic [1:0] SEG_KEY = 2'd1;
    localparam logic [1:0] SEG_CT  = 2'd2;
    localparam logic [1:0] SEG_SMP = 2'd3;

    localparam int GAP_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LOAD,
        ST_STROBE,
        ST_WAIT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/trace_tx_sequencer.sv
// trace_tx_sequencer: streams PT, KEY, CT and sensor samples byte by byte into a UART transmitter.
// The parent owns the byte mux and answers {rd_seg, rd_addr} one clock later on rd_data.
module trace_tx_sequencer
    import trace_tx_sequencer_pkg::*;
#(
    parameter int SAMPLES    = 2048,
    parameter int HDR_BYTES  = 16,
    parameter int GAP_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic [1:0]  rd_seg,
    output logic [10:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    output logic        frame_done
);

    localparam logic [10:0] HDR_LAST = 11'(HDR_BYTES - 1);
    localparam logic [10:0] SMP_LAST = 11'(SAMPLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);

    state_t            state;
    logic [GAP_W-1:0]  gap_cnt;
    logic              seg_end;

    assign seg_end = rd_addr == (rd_seg == SEG_SMP ? SMP_LAST : HDR_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            tx_dv      <= 1'b0;
            tx_byte    <= 8'd0;
            rd_seg     <= SEG_PT;
            rd_addr    <= 11'd0;
            frame_done <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            // abort outranks tx_done and gap expiry in the same cycle
            if (abort && state != ST_IDLE) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                tx_dv   <= 1'b0;
                rd_seg  <= SEG_PT;
                rd_addr <= 11'd0;
                gap_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        state   <= ST_ADDR;
                        busy    <= 1'b1;
                        rd_seg  <= SEG_PT;
                        rd_addr <= 11'd0;
                    end
                    ST_ADDR: state <= ST_LOAD;
                    ST_LOAD: begin
                        tx_byte <= rd_data;
                        tx_dv   <= 1'b1;
                        state   <= ST_STROBE;
                    end
                    ST_STROBE: begin
                        tx_dv <= 1'b0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: if (tx_done) begin
                        if (!seg_end) begin
                            rd_addr <= rd_addr + 11'd1;
                            state   <= ST_ADDR;
                        end else if (rd_seg != SEG_SMP) begin
                            rd_seg  <= rd_seg + 2'd1;
                            rd_addr <= 11'd0;
                            state   <= ST_ADDR;
                        end else if (GAP_CYCLES == 0) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end
                    ST_GAP: if (gap_cnt >= GAP_LAST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/trace_tx_sequencer.md
TRACE_TX_SEQUENCER -- requirements
Module: trace_tx_sequencer

Interface
REQ-001 SHALL have parameter SAMPLES, default 2048, giving the sensor-trace bytes per frame (range 1..2048).
REQ-002 SHALL have parameter HDR_BYTES, default 16, giving the bytes in each of the PT, KEY and CT segments.
REQ-003 SHALL have parameter GAP_CYCLES, default 4096, giving the idle clocks after a frame before frame_done.
REQ-004 SHALL have port clk, input, 1: the single clock, the UART clock domain.
REQ-005 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: a single-cycle pulse that requests one frame.
REQ-007 SHALL have port abort, input, 1: synchronous request to abandon the current frame.
REQ-008 SHALL have port busy, output, 1: high from frame acceptance until return to IDLE.
REQ-009 SHALL have port rd_seg, output, 2: the segment being read (0=PT, 1=KEY, 2=CT, 3=SAMPLES).
REQ-010 SHALL have port rd_addr, output, 11: the byte index within the segment.
REQ-011 SHALL have port rd_data, input, 8: the byte at {rd_seg, rd_addr}, valid exactly 1 clk after the address is presented.
REQ-012 SHALL have port tx_dv, output, 1: a one-cycle strobe to the uart_tx block.
REQ-013 SHALL have port tx_byte, output, 8: the byte to transmit, stable from tx_dv until tx_done.
REQ-014 SHALL have port tx_done, input, 1: the uart_tx byte-complete pulse.
REQ-015 SHALL have port frame_done, output, 1: a one-cycle pulse when a frame and its gap have completed.

Function
REQ-016 SHALL send each frame in this order: PT bytes 0..HDR_BYTES-1, KEY bytes 0..HDR_BYTES-1, CT bytes 0..HDR_BYTES-1, then SAMPLES bytes 0..SAMPLES-1, for 3*HDR_BYTES+SAMPLES bytes in total.
REQ-017 SHALL use the FSM states IDLE, ADDR, LOAD, STROBE, WAIT, GAP.
REQ-018 IDLE SHALL move to ADDR, with rd_seg=0, rd_addr=0 and busy=1, when start=1; otherwise it SHALL stay in IDLE.
REQ-019 ADDR SHALL hold the address for one cycle and then move to LOAD.
REQ-020 LOAD SHALL register tx_byte<=rd_data and then move to STROBE.
REQ-021 STROBE SHALL drive tx_dv=1 for exactly one cycle and then move to WAIT.
REQ-022 WAIT SHALL stay in WAIT until tx_done=1, then advance as follows:
  - if not the last byte of the segment: rd_addr+1, go to ADDR;
  - if the last byte of a segment other than SAMPLES: rd_seg+1, rd_addr=0, go to ADDR;
  - if the last byte of SAMPLES: go to GAP.
REQ-023 GAP SHALL count GAP_CYCLES clocks, then pulse frame_done for 1 cycle, clear busy and return to IDLE.
REQ-024 Latency from start to the first tx_dv SHALL be exactly 3 clocks.
REQ-025 A start received while busy=1 SHALL be ignored, not queued.
REQ-026 A tx_done received outside WAIT SHALL be ignored.
REQ-027 A tx_done arriving in the same cycle as the tx_dv strobe SHALL NOT count as the completion of that byte.
REQ-028 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next clock with busy=0, tx_dv=0 and no frame_done pulse.
REQ-029 abort SHALL take priority over tx_done and over GAP expiry arriving in the same cycle.
REQ-030 rd_addr SHALL never exceed the segment length minus 1, and SHALL never wrap within a frame.
REQ-031 The GAP counter SHALL be 13 bits wide and saturate-compare against GAP_CYCLES-1.
REQ-032 GAP_CYCLES=0 SHALL produce frame_done on the cycle after the last tx_done.

Reset
REQ-033 rstn=0 SHALL asynchronously force: state=IDLE, busy=0, tx_dv=0, tx_byte=0, rd_seg=0, rd_addr=0, frame_done=0, gap counter=0.
REQ-034 Reset asserted mid-frame SHALL discard all progress; the next start after reset release SHALL begin again at PT byte 0.
REQ-035 Reset release SHALL need no synchronising inside this block; the parent provides a deasserted-synchronous rstn.

Structure
REQ-036 The shared package SHALL hold the segment codes (SEG_PT=0, SEG_KEY=1, SEG_CT=2, SEG_SMP=3) and the FSM state encoding.
REQ-037 The module SHALL contain no sub-module.
REQ-038 The byte mux from the PT/KEY/CT registers and the sample RAM SHALL stay in the parent, as a one-cycle registered read.

Verification
REQ-039 Scenario 1: SAMPLES=4, GAP_CYCLES=8, memory model pattern byte=seg*16+addr, one start -> 52 tx_dv pulses with values 00..0F, 10..1F, 20..2F, 30..33, then frame_done 8 clocks after the last tx_done.
REQ-040 Scenario 2: start at cycle 0 -> first tx_dv at cycle 3, and tx_byte equals rd_data for {0,0}.
REQ-041 Scenario 3: a second start pulsed during KEY byte 5 -> exactly 52 bytes sent and a single frame_done.
REQ-042 Scenario 4: abort asserted in WAIT for CT byte 2 -> IDLE next clock, busy=0, no frame_done; a following start restarts at PT byte 0.
REQ-043 Scenario 5: rstn pulsed low during SAMPLES byte 1 -> all outputs 0 immediately (asynchronous), and a new frame restarts at PT byte 0.
REQ-044 Scenario 6: tx_done held high for 3 cycles, and also asserted coincident with tx_dv -> each byte counted once, no byte skipped.
